serial_subtractor: RTL and testbench

Bit-serial unsigned subtractor that computes `a - b` one bit per clock, LSB first, using a single half/full-subtractor cell and a borrow flip-flop. It is the subtraction counterpart of the team's adder cells and sits behind a simple start/done handshake. It serves as the sequential building block for area-constrained datapaths that cannot afford a parallel subtractor.

---
 rtl/serial_subtractor.sv | 146 ++++++++++++++
 tb/tb_serial_subtractor.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial unsigned subtractor: computes (a - b) mod 2^WIDTH one bit per
// clock, LSB first, with a single full-subtractor cell and a borrow flop.
// A start/done handshake frames each operation. WIDTH bits take WIDTH cycles
// from the accepting edge to the done pulse.
//
// Parameters
//   WIDTH       operand/result width in bits (2..32)
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   start       request; sampled only when not busy (IDLE or DONE)
//   a           minuend, captured on the accepting edge
//   b           subtrahend, captured on the accepting edge
//   diff        registered result (a - b) mod 2^WIDTH, held until next done
//   borrow_out  registered final borrow (1 iff a < b), held with diff
//   busy        high while bits are being processed
//   done        one-cycle pulse: diff/borrow_out have just been updated
// ---------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Full-subtractor cell: difference bit.
  function automatic logic sub_diff(input logic x, input logic y, input logic bin);
    return x ^ y ^ bin;
  endfunction

  // Full-subtractor cell: borrow out. A borrow is generated when x=0,y=1 and
  // propagated when x==y.
  function automatic logic sub_borrow(input logic x, input logic y, input logic bin);
    return (~x & y) | (~(x ^ y) & bin);
  endfunction

  state_t           state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] rd;
  logic             br;
  logic [CNT_W-1:0] cnt;

  logic             d_bit;
  logic             br_next;
  logic [WIDTH-1:0] rd_next;

  // Bit cell: operates on the current LSBs and the stored borrow.
  assign d_bit   = sub_diff(ra[0], rb[0], br);
  assign br_next = sub_borrow(ra[0], rb[0], br);
  // Result bits enter at the MSB so that after WIDTH shifts the LSB result
  // bit has arrived at position 0.
  assign rd_next = {d_bit, rd[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ra         <= '0;
      rb         <= '0;
      rd         <= '0;
      br         <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            ra    <= a;
            rb    <= b;
            rd    <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
          end
        end

        RUN: begin
          // start is deliberately ignored here: no queuing of requests.
          ra  <= ra >> 1;
          rb  <= rb >> 1;
          rd  <= rd_next;
          br  <= br_next;
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_BIT) begin
            diff       <= rd_next;
            borrow_out <= br_next;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end
        end

        DONE: begin
          done <= 1'b0;
          // Accepting here gives back-to-back operation with no IDLE gap.
          if (start) begin
            ra    <= a;
            rb    <= b;
            rd    <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
//
// Self-checking bench for serial_subtractor. An 8-bit instance runs a table
// of directed vectors plus hand-written back-to-back, busy-ignore and
// reset-mid-run sequences; a 4-bit instance is swept over every operand pair.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [7:0] diff8;
  logic       bo8, busy8, done8;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic [3:0] diff4;
  logic       bo4, busy4, done4;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .diff(diff8), .borrow_out(bo8), .busy(busy8), .done(done8)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .diff(diff4), .borrow_out(bo4), .busy(busy4), .done(done4)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_diff;
    logic       exp_bo;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // One complete 8-bit operation with a single-cycle start pulse.
  task automatic run8(input logic [7:0] ta, input logic [7:0] tb,
                      input logic [7:0] ed, input logic eb, input string tag);
    int bad;
    bad = 0;
    @(negedge clk);
    a8 = ta; b8 = tb; start8 = 1'b1;
    @(negedge clk);                     // after accepting edge E0
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);
    if (busy8 !== 1'b1 || done8 !== 1'b0) bad++;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);                   // after edge E(k)
      if (k < 8) begin
        if (busy8 !== 1'b1 || done8 !== 1'b0) bad++;
      end
    end
    chk({tag, " busy window"}, bad, 0);
    chk({tag, " done"}, done8, 1'b1);
    chk({tag, " busy at done"}, busy8, 1'b0);
    chk({tag, " diff"}, diff8, ed);
    chk({tag, " borrow"}, bo8, eb);
    @(negedge clk);
    chk({tag, " done single"}, done8, 1'b0);
  endtask

  // One complete 4-bit operation; returns number of discrepancies.
  task automatic run4(input logic [3:0] ta, input logic [3:0] tb, output int bad);
    logic [4:0] full;
    bad = 0;
    full = {1'b0, ta} - {1'b0, tb};
    @(negedge clk);
    a4 = ta; b4 = tb; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k < 4 && (done4 !== 1'b0 || busy4 !== 1'b1)) bad++;
    end
    if (done4 !== 1'b1) bad++;
    if (diff4 !== full[3:0]) bad++;
    if (bo4 !== (ta < tb)) bad++;
  endtask

  initial begin
    int bad;
    int ndone;
    logic [7:0] seen;

    vecs[0] = '{8'h5A, 8'h3C, 8'h1E, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 8'hFF, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
    vecs[3] = '{8'h80, 8'h7F, 8'h01, 1'b0};
    vecs[4] = '{8'h3C, 8'h5A, 8'hE2, 1'b1};
    vecs[5] = '{8'h01, 8'hFF, 8'h02, 1'b1};
    vecs[6] = '{8'hFF, 8'h00, 8'hFF, 1'b0};

    // Reset state
    #12;
    chk("reset diff", diff8, 8'h00);
    chk("reset borrow", bo8, 1'b0);
    chk("reset busy", busy8, 1'b0);
    chk("reset done", done8, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 7; i++)
      run8(vecs[i].a, vecs[i].b, vecs[i].exp_diff, vecs[i].exp_bo, $sformatf("vec%0d", i));

    // Back-to-back: start held, operands changed in the DONE cycle
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20; start8 = 1'b1;
    for (int k = 0; k <= 8; k++) @(negedge clk);
    chk("b2b first done", done8, 1'b1);
    chk("b2b first diff", diff8, 8'hF0);
    chk("b2b first borrow", bo8, 1'b1);
    a8 = 8'h33; b8 = 8'h11;
    @(negedge clk);
    chk("b2b no idle busy", busy8, 1'b1);
    start8 = 1'b0;
    for (int k = 1; k <= 8; k++) @(negedge clk);
    chk("b2b second done", done8, 1'b1);
    chk("b2b second diff", diff8, 8'h22);
    chk("b2b second borrow", bo8, 1'b0);

    // Busy ignore: new start during RUN must not disturb the operation
    @(negedge clk);
    a8 = 8'h5A; b8 = 8'h3C; start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h01; start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    ndone = 0; seen = 8'h00;
    for (int k = 0; k < 20; k++) begin
      if (done8 === 1'b1) begin
        ndone++;
        seen = diff8;
      end
      @(negedge clk);
    end
    chk("ignore done count", ndone, 1);
    chk("ignore diff at done", seen, 8'h1E);
    chk("ignore diff held", diff8, 8'h1E);
    chk("ignore borrow held", bo8, 1'b0);

    // Reset mid-run
    @(negedge clk);
    a8 = 8'hC3; b8 = 8'h12; start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst busy", busy8, 1'b0);
    chk("midrst done", done8, 1'b0);
    chk("midrst diff", diff8, 8'h00);
    chk("midrst borrow", bo8, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done8 === 1'b1 || busy8 === 1'b1) ndone++;
    end
    chk("midrst no activity", ndone, 0);
    run8(8'h05, 8'h03, 8'h02, 1'b0, "after rst");

    // Exhaustive 4-bit sweep
    ndone = 0;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        run4(4'(i), 4'(j), bad);
        if (bad != 0) ndone++;
        chk($sformatf("w4 %0h-%0h", i, j), bad, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
